// File: rtl/regfile_writeback_queue.sv
// Write-side front end for the 32x64 register file: clear sweep of R0..R30 after reset,
// then an in-order writeback FIFO draining one write per cycle. Optional macro REGFILE_WB_BYPASS_EN.
module regfile_writeback_queue #(
  parameter int N     = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [4:0]               in_addr,
  input  logic [N-1:0]             in_data,
  input  logic                     wb_hold,
  output logic [4:0]               DA,
  output logic [N-1:0]             D,
  output logic                     W,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     busy
`ifdef REGFILE_WB_BYPASS_EN
  ,
  input  logic [4:0]               SA,
  input  logic [4:0]               SB,
  output logic                     bypA_hit,
  output logic                     bypB_hit,
  output logic [N-1:0]             bypA_data,
  output logic [N-1:0]             bypB_data
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [4:0] XZR       = 5'd31;
  localparam logic [4:0] SWEEP_END = 5'd30;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t          state_q, state_d;
  logic [4:0]      sweep_q, sweep_d;
  logic [PW-1:0]   head_q, tail_q;
  logic [CW-1:0]   count_q;
  logic [4:0]      addr_mem [DEPTH];
  logic [N-1:0]    data_mem [DEPTH];

  logic full, pop, push_acc, push_wr;

  // Control state: FSM and sweep index
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_INIT;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    if (state_q == S_INIT) begin
      if (sweep_q == SWEEP_END) begin
        state_d = S_RUN;
        sweep_d = '0;
      end else begin
        sweep_d = sweep_q + 5'd1;
      end
    end
  end

  // in_ready looks only at the registered count, so a full FIFO popping this cycle still refuses
  assign full     = (count_q == CW'(DEPTH));
  assign pop      = !reset && (state_q == S_RUN) && (count_q != '0) && !wb_hold;
  assign push_acc = in_valid && in_ready;
  assign push_wr  = push_acc && (in_addr != XZR);

  always_comb begin
    W        = 1'b0;
    DA       = '0;
    D        = '0;
    in_ready = 1'b0;
    if (!reset) begin
      if (state_q == S_INIT) begin
        W  = 1'b1;
        DA = sweep_q;
      end else begin
        in_ready = !full;
        if (count_q != '0 && !wb_hold) begin
          W  = 1'b1;
          DA = addr_mem[head_q];
          D  = data_mem[head_q];
        end
      end
    end
  end

  assign count = reset ? '0 : count_q;
  assign busy  = reset || (state_q == S_INIT) || (count_q != '0);

  // FIFO pointers and occupancy
  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (pop)     head_q <= head_q + PW'(1);
      if (push_wr) tail_q <= tail_q + PW'(1);
      case ({push_wr, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage carries no reset; occupancy alone defines which entries are live
  always_ff @(posedge clock) begin
    if (push_wr) begin
      addr_mem[tail_q] <= in_addr;
      data_mem[tail_q] <= in_data;
    end
  end

`ifdef REGFILE_WB_BYPASS_EN
  // Scan oldest to youngest so the youngest match overrides; the head counts as live
  function automatic logic [N:0] lookup(input logic [4:0] sa);
    logic [N:0]    r;
    logic [PW-1:0] idx;
    r   = '0;
    idx = '0;
    if (!reset && state_q == S_RUN && sa != XZR) begin
      for (int i = 0; i < DEPTH; i++) begin
        idx = head_q + PW'(i);
        if (CW'(i) < count_q && addr_mem[idx] == sa) r = {1'b1, data_mem[idx]};
      end
    end
    return r;
  endfunction

  always_comb begin
    {bypA_hit, bypA_data} = lookup(SA);
    {bypB_hit, bypB_data} = lookup(SB);
  end
`endif

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Directed bench for regfile_writeback_queue with a queue-based reference model
// checked every cycle, plus literal expectations for each scenario.
module tb_regfile_writeback_queue;
  localparam int N     = 64;
  localparam int DEPTH = 4;

  logic                   clock;
  logic                   reset;
  logic                   in_valid;
  logic                   in_ready;
  logic [4:0]             in_addr;
  logic [N-1:0]           in_data;
  logic                   wb_hold;
  logic [4:0]             DA;
  logic [N-1:0]           D;
  logic                   W;
  logic [$clog2(DEPTH):0] count;
  logic                   busy;
`ifdef REGFILE_WB_BYPASS_EN
  logic [4:0]   SA, SB;
  logic         bypA_hit, bypB_hit;
  logic [N-1:0] bypA_data, bypB_data;
`endif

  regfile_writeback_queue #(.N(N), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .wb_hold(wb_hold),
    .DA(DA), .D(D), .W(W), .count(count), .busy(busy)
`ifdef REGFILE_WB_BYPASS_EN
    , .SA(SA), .SB(SB), .bypA_hit(bypA_hit), .bypB_hit(bypB_hit),
    .bypA_data(bypA_data), .bypB_data(bypB_data)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: sweep position plus an ordered list of pending writes
  typedef struct { logic [4:0] a; logic [63:0] d; } ent_t;
  ent_t q[$];
  bit   m_init  = 1'b1;
  int   m_sweep = 0;

  always @(posedge clock) begin
    bit do_pop, do_acc;
    if (reset) begin
      q.delete();
      m_init  = 1'b1;
      m_sweep = 0;
    end else if (m_init) begin
      if (m_sweep == 30) m_init = 1'b0;
      else m_sweep++;
    end else begin
      do_pop = (q.size() > 0) && !wb_hold;
      do_acc = in_valid && (q.size() != DEPTH);
      if (do_pop) void'(q.pop_front());
      if (do_acc && in_addr != 5'd31) q.push_back('{a: in_addr, d: in_data});
    end
  end

  always @(negedge clock) begin
    logic        e_w, e_rdy, e_busy;
    logic [4:0]  e_da;
    logic [63:0] e_d;
    int          e_cnt;
    if (chk_en) begin
      e_w = 0; e_da = 0; e_d = 0; e_rdy = 0; e_cnt = 0; e_busy = 1;
      if (!reset) begin
        if (m_init) begin
          e_w = 1; e_da = 5'(m_sweep);
        end else begin
          e_cnt  = q.size();
          e_rdy  = (e_cnt != DEPTH);
          e_busy = (e_cnt != 0);
          if (e_cnt > 0 && !wb_hold) begin
            e_w = 1; e_da = q[0].a; e_d = q[0].d;
          end
        end
      end
      chk("model_W", W, e_w);
      chk("model_DA", DA, e_da);
      chk("model_D", D, e_d);
      chk("model_in_ready", in_ready, e_rdy);
      chk("model_count", count, e_cnt);
      chk("model_busy", busy, e_busy);
`ifdef REGFILE_WB_BYPASS_EN
      begin
        logic ha, hb; logic [63:0] da, db;
        ha = 0; hb = 0; da = 0; db = 0;
        if (!reset && !m_init) begin
          foreach (q[i]) begin
            if (SA != 5'd31 && q[i].a == SA) begin ha = 1; da = q[i].d; end
            if (SB != 5'd31 && q[i].a == SB) begin hb = 1; db = q[i].d; end
          end
        end
        chk("model_bypA_hit", bypA_hit, ha);
        chk("model_bypA_data", bypA_data, da);
        chk("model_bypB_hit", bypB_hit, hb);
        chk("model_bypB_data", bypB_data, db);
      end
`endif
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic probe();
    @(negedge clock);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc_cycle;
    reset = 1; in_valid = 0; in_addr = 0; in_data = 0; wb_hold = 0;
`ifdef REGFILE_WB_BYPASS_EN
    SA = 0; SB = 0;
`endif
    chk_en = 1'b1;
    repeat (2) tick();
    probe();
    chk("reset_W", W, 0);
    chk("reset_count", count, 0);
    chk("reset_busy", busy, 1);
    chk("reset_in_ready", in_ready, 0);
    tick();
    reset = 0;

    // Clear sweep: DA 0..30 on consecutive cycles
    for (int i = 0; i < 31; i++) begin
      probe();
      chk("sweep_W", W, 1);
      chk("sweep_DA", DA, i);
      chk("sweep_D", D, 0);
      chk("sweep_in_ready", in_ready, 0);
    end
    probe();
    chk("post_sweep_W", W, 0);
    chk("post_sweep_in_ready", in_ready, 1);
    chk("post_sweep_busy", busy, 0);

    // Single write, one-cycle latency
    tick();
    in_valid = 1; in_addr = 5; in_data = 64'hDEAD_BEEF;
    tick();
    in_valid = 0;
    probe();
    chk("single_W", W, 1);
    chk("single_DA", DA, 5);
    chk("single_D", D, 64'hDEAD_BEEF);
    chk("single_count", count, 1);
    probe();
    chk("single_count_after", count, 0);
    chk("single_W_after", W, 0);

    // Fill under hold, fifth request waits, then in-order drain
    tick();
    wb_hold = 1;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1; in_addr = 5'(k + 1); in_data = 64'h10 + 64'(k);
      tick();
    end
    in_addr = 5; in_data = 64'h14;
    probe();
    chk("full_count", count, 4);
    chk("full_in_ready", in_ready, 0);
    tick();
    chk("full_count_held", count, 4);
    wb_hold = 0;
    acc_cycle = -1;
    for (int c = 0; c < 6; c++) begin
      bit acc;
      probe();
      chk("drain_W", W, (c < 5) ? 1 : 0);
      chk("drain_DA", DA, (c < 5) ? 64'(c + 1) : 64'd0);
      if (c < 5) chk("drain_D", D, 64'h10 + 64'(c));
      acc = in_valid && in_ready;
      if (acc && acc_cycle < 0) acc_cycle = c;
      tick();
      if (acc) in_valid = 0;
    end
    chk("fifth_accept_cycle", acc_cycle, 1);
    in_valid = 0;

    // XZR request accepted and dropped
    in_valid = 1; in_addr = 31; in_data = 64'hFFFF;
    probe();
    chk("xzr_in_ready", in_ready, 1);
    tick();
    in_valid = 0;
    probe();
    chk("xzr_count", count, 0);
    chk("xzr_W", W, 0);

`ifdef REGFILE_WB_BYPASS_EN
    // Bypass: youngest match wins, XZR never hits
    tick();
    wb_hold = 1;
    in_valid = 1; in_addr = 7; in_data = 64'h11;
    tick();
    in_data = 64'h22;
    tick();
    in_valid = 0; SA = 7; SB = 31;
    probe();
    chk("byp_A_hit", bypA_hit, 1);
    chk("byp_A_data", bypA_data, 64'h22);
    chk("byp_B_hit", bypB_hit, 0);
    chk("byp_B_data", bypB_data, 0);
    tick();
    wb_hold = 0;
    repeat (3) tick();
    SA = 0; SB = 0;
`endif

    // Reset with entries queued; sweep restarts at 0 and ignores hold
    tick();
    wb_hold = 1;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1; in_addr = 5'(8 + k); in_data = 64'hA0 + 64'(k);
      tick();
    end
    in_valid = 0;
    probe();
    chk("pre_reset_count", count, 3);
    tick();
    reset = 1;
    probe();
    chk("mid_reset_count", count, 0);
    chk("mid_reset_W", W, 0);
    tick();
    reset = 0;
    probe();
    chk("restart_W", W, 1);
    chk("restart_DA", DA, 0);
    chk("restart_count", count, 0);
    probe();
    chk("restart_DA1", DA, 1);
    wb_hold = 0;
    repeat (32) tick();
    probe();
    chk("final_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
